acp_cmd_writer: RTL
===================

Name: acp_cmd_writer

Overview:
Bus-master side of the ACP register-write interface. Accepts (register index, 16-bit value) commands from the CPU or a song sequencer into a small FIFO, then drives the two-phase protocol into the ACP: an address write followed by a data write, each held until the slave acks. It sits between the command source and the ACP's m_bus_in/m_ctrl_in/m_ack pins. It skips redundant address phases and recovers from a missing ack by timing out.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2).
TIMEOUT, 255, cycles a phase may wait for ack before abort (≥1).
ADDR_CACHE, 1, 1 = skip the address phase when the index equals the last acked address.

Ports:
clk50MHz  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  FIFO can accept; transfer = cmd_valid & cmd_ready.
cmd_addr  in  3  ACP register index 0..7 (ch0 note, ch0 fx, … ch3 fx).
cmd_data  in  16  register value.
bus_out  out  32  to ACP m_bus_in.
ctrl_out  out  8  to ACP m_ctrl_in: 8'h00 idle, 8'h01 address write, 8'h02 data write.
ack  in  1  from ACP m_ack; one-cycle pulse accepting the current phase.
busy  out  1  FIFO non-empty or FSM not IDLE.
timeout_err  out  1  sticky abort flag.
err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (async assert, sync release): FIFO empty, state IDLE, ctrl_out=0, bus_out=0, busy=0, timeout_err=0, addr_valid=0, last_addr=0. cmd_ready=!full, so it reads 1 in reset.
- FIFO: 19-bit entries {addr,data}. Push on cmd_valid&cmd_ready. Simultaneous push and pop is allowed when full and when empty (the empty case pops next cycle). Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ADDR, DATA.
  - IDLE: if FIFO non-empty, pop into cur_addr/cur_data. Next state is DATA if ADDR_CACHE & addr_valid & cur_addr==last_addr, else ADDR.
  - ADDR: ctrl_out=8'h01, bus_out={29'b0,cur_addr}. On sampled ack: last_addr<=cur_addr, addr_valid<=1, go to DATA.
  - DATA: ctrl_out=8'h02, bus_out={16'b0,cur_data}. On sampled ack, go to IDLE.
- ctrl_out and bus_out are registered and update on the edge that enters a state. They hold constant for the whole phase and return to 0 in IDLE.
- Latency: a push into an empty, idle block shows ctrl_out=8'h01 two edges later. After a DATA ack, the next queued command's first phase appears two edges later (IDLE costs one cycle).
- ack is ignored in IDLE, and any ack arriving while idle is not remembered. An ack arriving in the same cycle as the timeout is treated as ack (ack wins).
- Timeout: the phase counter clears when a phase is entered and increments each cycle without ack. When it reaches TIMEOUT:
  - abandon the command (no retry);
  - set timeout_err and clear addr_valid (slave address is unknown);
  - go to IDLE.
- err_clr clears timeout_err. If set and clear happen in the same cycle, set wins.
- Reset during any phase forces ctrl_out=0 immediately and flushes the FIFO. The in-flight command is lost.
- busy = (state!=IDLE) | !empty.

Decomposition:
- Package acp_pkg holds:
  - state encoding;
  - CTRL_IDLE/CTRL_ADDR/CTRL_DATA codes;
  - register index constants REG_CH0_NOTE=0, REG_CH0_FX=1 … REG_CH3_FX=7;
  - note-register field positions (len [10:8], vol [7:6], note [5:0]);
  - fx-register field positions (optB [9:8], optA [7:6], sel [5:4], dec [3:2], atk [1:0]).
- Sub-module acp_cmd_fifo: parameterised synchronous FIFO (WIDTH=19, DEPTH), async active-low reset, full/empty outputs.

Test Plan:
1. Hold reset_n=0 with cmd_valid=1 → ctrl_out=0, bus_out=0, busy=0, timeout_err=0, and no push takes effect. Deassert reset → cmd_ready=1.
2. Push addr=2, data=16'h0345; ack one cycle after each phase starts → ctrl_out shows 01/bus 0x00000002, then 02/bus 0x00000345, then 00. busy falls the cycle after the data ack.
3. Push addr=5 data=0x00C7, then addr=5 data=0x0003 → exactly one 8'h01 phase in total and two 8'h02 phases in order. With ADDR_CACHE=0 → two 8'h01 phases.
4. Hold ack=0 and push 6 commands back-to-back → cmd_ready drops once 4 are queued (1 in flight). Releasing ack drains all 5 accepted commands in order, and the 6th is pushed once ready returns.
5. Never ack with TIMEOUT=8 → after 8 cycles in ADDR, timeout_err=1 and ctrl_out=0. A following same-addr command still issues 8'h01. err_clr=1 clears the flag, but not when asserted in the same cycle as a new timeout.
6. Assert reset_n=0 mid-DATA with 3 commands queued → ctrl_out=0 asynchronously. After release: FIFO empty, busy=0, and the next command performs an address phase.

Source files
------------

// File: rtl/acp_pkg.sv
// rtl/acp_pkg.sv - shared types and constants for the ACP command writer
//
// Purpose: FSM state encoding, ACP control codes, register index map,
// register field positions and a packed command record.
// Ports: none (package).

package acp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } acp_state_e;

    localparam logic [7:0] CTRL_IDLE = 8'h00;
    localparam logic [7:0] CTRL_ADDR = 8'h01;
    localparam logic [7:0] CTRL_DATA = 8'h02;

    localparam int ACP_ADDR_W = 3;
    localparam int ACP_DATA_W = 16;
    localparam int ACP_CMD_W  = ACP_ADDR_W + ACP_DATA_W;

    localparam logic [2:0] REG_CH0_NOTE = 3'd0;
    localparam logic [2:0] REG_CH0_FX   = 3'd1;
    localparam logic [2:0] REG_CH1_NOTE = 3'd2;
    localparam logic [2:0] REG_CH1_FX   = 3'd3;
    localparam logic [2:0] REG_CH2_NOTE = 3'd4;
    localparam logic [2:0] REG_CH2_FX   = 3'd5;
    localparam logic [2:0] REG_CH3_NOTE = 3'd6;
    localparam logic [2:0] REG_CH3_FX   = 3'd7;

    // Note register: len [10:8], vol [7:6], note [5:0]
    localparam int NOTE_LEN_MSB  = 10;
    localparam int NOTE_LEN_LSB  = 8;
    localparam int NOTE_VOL_MSB  = 7;
    localparam int NOTE_VOL_LSB  = 6;
    localparam int NOTE_NOTE_MSB = 5;
    localparam int NOTE_NOTE_LSB = 0;

    // Fx register: optB [9:8], optA [7:6], sel [5:4], dec [3:2], atk [1:0]
    localparam int FX_OPTB_MSB = 9;
    localparam int FX_OPTB_LSB = 8;
    localparam int FX_OPTA_MSB = 7;
    localparam int FX_OPTA_LSB = 6;
    localparam int FX_SEL_MSB  = 5;
    localparam int FX_SEL_LSB  = 4;
    localparam int FX_DEC_MSB  = 3;
    localparam int FX_DEC_LSB  = 2;
    localparam int FX_ATK_MSB  = 1;
    localparam int FX_ATK_LSB  = 0;

    typedef struct packed {
        logic [ACP_ADDR_W-1:0] addr;
        logic [ACP_DATA_W-1:0] data;
    } acp_cmd_t;

    function automatic logic [15:0] pack_note(input logic [2:0] len,
                                              input logic [1:0] vol,
                                              input logic [5:0] note);
        logic [15:0] r;
        r = '0;
        r[NOTE_LEN_MSB:NOTE_LEN_LSB]   = len;
        r[NOTE_VOL_MSB:NOTE_VOL_LSB]   = vol;
        r[NOTE_NOTE_MSB:NOTE_NOTE_LSB] = note;
        return r;
    endfunction

    function automatic logic [15:0] pack_fx(input logic [1:0] optb,
                                            input logic [1:0] opta,
                                            input logic [1:0] sel,
                                            input logic [1:0] dec,
                                            input logic [1:0] atk);
        logic [15:0] r;
        r = '0;
        r[FX_OPTB_MSB:FX_OPTB_LSB] = optb;
        r[FX_OPTA_MSB:FX_OPTA_LSB] = opta;
        r[FX_SEL_MSB:FX_SEL_LSB]   = sel;
        r[FX_DEC_MSB:FX_DEC_LSB]   = dec;
        r[FX_ATK_MSB:FX_ATK_LSB]   = atk;
        return r;
    endfunction

endpackage

// File: rtl/acp_cmd_fifo.sv
// rtl/acp_cmd_fifo.sv - synchronous command FIFO with async active-low reset
//
// Purpose: small power-of-two FIFO holding {addr,data} commands.
// Ports:
//   clk50MHz, reset_n    clock, async active-low reset (flushes pointers)
//   push, wdata          write strobe and entry; ignored when full unless popping
//   pop                  read strobe; ignored when empty
//   rdata                head entry (valid while !empty)
//   full, empty          occupancy flags

module acp_cmd_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk50MHz,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_DEPTH = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_DEPTH);
    assign empty   = (count == '0);
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; the pointers alone define the contents.
    always_ff @(posedge clk50MHz) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk50MHz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/acp_cmd_writer.sv
// rtl/acp_cmd_writer.sv - ACP register-write bus master with command FIFO
//
// Purpose: queues (index,value) commands and drives the two-phase ACP write
// (address phase then data phase, each held until ack), skipping the address
// phase when the slave already holds that index, aborting on ack timeout.
// Ports:
//   clk50MHz, reset_n               clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_addr[2:0], cmd_data[15:0]   register index and value
//   bus_out[31:0], ctrl_out[7:0]    to ACP m_bus_in / m_ctrl_in
//   ack                             phase accept pulse from ACP
//   busy                            FIFO non-empty or phase in progress
//   timeout_err, err_clr            sticky abort flag and its clear

module acp_cmd_writer
    import acp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255,
    parameter int ADDR_CACHE = 1
) (
    input  logic        clk50MHz,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic [31:0] bus_out,
    output logic [7:0]  ctrl_out,
    input  logic        ack,
    output logic        busy,
    output logic        timeout_err,
    input  logic        err_clr
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    acp_state_e state;
    logic [2:0]    cur_addr;
    logic [15:0]   cur_data;
    logic [2:0]    last_addr;
    logic          addr_valid;
    logic [TW-1:0] phase_cnt;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    acp_cmd_t      fifo_wdata;
    acp_cmd_t      fifo_rdata;
    logic          cache_hit;

    assign cmd_ready  = ~fifo_full;
    assign fifo_push  = cmd_valid & cmd_ready;
    assign fifo_pop   = (state == ST_IDLE) & ~fifo_empty;
    assign fifo_wdata = '{addr: cmd_addr, data: cmd_data};
    assign busy       = (state != ST_IDLE) | ~fifo_empty;
    assign cache_hit  = (ADDR_CACHE != 0) && addr_valid && (fifo_rdata.addr == last_addr);

    acp_cmd_fifo #(
        .WIDTH (ACP_CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk50MHz (clk50MHz),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .wdata    (fifo_wdata),
        .pop      (fifo_pop),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            ctrl_out    <= CTRL_IDLE;
            bus_out     <= '0;
            cur_addr    <= '0;
            cur_data    <= '0;
            last_addr   <= '0;
            addr_valid  <= 1'b0;
            timeout_err <= 1'b0;
            phase_cnt   <= '0;
        end else begin
            // A timeout set later in this block overrides the clear.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_addr  <= fifo_rdata.addr;
                        cur_data  <= fifo_rdata.data;
                        phase_cnt <= '0;
                        if (cache_hit) begin
                            state    <= ST_DATA;
                            ctrl_out <= CTRL_DATA;
                            bus_out  <= {16'b0, fifo_rdata.data};
                        end else begin
                            state    <= ST_ADDR;
                            ctrl_out <= CTRL_ADDR;
                            bus_out  <= {29'b0, fifo_rdata.addr};
                        end
                    end
                end
                ST_ADDR: begin
                    if (ack) begin
                        last_addr  <= cur_addr;
                        addr_valid <= 1'b1;
                        phase_cnt  <= '0;
                        state      <= ST_DATA;
                        ctrl_out   <= CTRL_DATA;
                        bus_out    <= {16'b0, cur_data};
                    end else if (phase_cnt == T_LAST) begin
                        // Slave may have latched a partial address; forget it.
                        state       <= ST_IDLE;
                        ctrl_out    <= CTRL_IDLE;
                        bus_out     <= '0;
                        timeout_err <= 1'b1;
                        addr_valid  <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + T_ONE;
                    end
                end
                ST_DATA: begin
                    if (ack) begin
                        state    <= ST_IDLE;
                        ctrl_out <= CTRL_IDLE;
                        bus_out  <= '0;
                    end else if (phase_cnt == T_LAST) begin
                        state       <= ST_IDLE;
                        ctrl_out    <= CTRL_IDLE;
                        bus_out     <= '0;
                        timeout_err <= 1'b1;
                        addr_valid  <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + T_ONE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ctrl_out <= CTRL_IDLE;
                    bus_out  <= '0;
                end
            endcase
        end
    end

endmodule
